// File: rtl/order_ingress_arbiter.sv
// order_ingress_arbiter
// Shares the matching engine's single order input between the UDP order FIFO
// and the bot FIFO. UDP traffic has priority. A bounded-burst guard stops a
// continuous UDP stream from starving a pending bot order. The block pops one
// word, strobes it to the engine, then waits for the engine to finish before
// it grants again.
//
// Ports:
//   clk, rst_n                clock (rising edge) / async active-low reset
//   udp_empty, udp_dout       UDP FIFO status and read data (1-cycle latency)
//   udp_rd_en                 UDP FIFO pop pulse
//   bot_empty, bot_dout       bot FIFO status and read data (1-cycle latency)
//   bot_rd_en                 bot FIFO pop pulse
//   eng_busy                  engine busy
//   eng_valid                 one-cycle order strobe to the engine
//   eng_data, eng_src         order word and its source (1 = bot)
//   udp_fifo_has_data         ~udp_empty, exported to the bot
//   udp_grant_cnt             saturating count of issued UDP orders
//   bot_grant_cnt             saturating count of issued bot orders
module order_ingress_arbiter #(
  parameter int unsigned MAX_UDP_BURST = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             udp_empty,
  input  logic [31:0]      udp_dout,
  output logic             udp_rd_en,
  input  logic             bot_empty,
  input  logic [31:0]      bot_dout,
  output logic             bot_rd_en,
  input  logic             eng_busy,
  output logic             eng_valid,
  output logic [31:0]      eng_data,
  output logic             eng_src,
  output logic             udp_fifo_has_data,
  output logic [CNT_W-1:0] udp_grant_cnt,
  output logic [CNT_W-1:0] bot_grant_cnt
);

  localparam int unsigned BW = (MAX_UDP_BURST > 0) ? $clog2(MAX_UDP_BURST + 1) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_UDP_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_PEND,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_sel;     // source of the grant in flight (1 = bot)
  logic [BW-1:0] r_burst;

  logic w_decide;
  logic w_guard_trip;
  logic w_grant_udp;
  logic w_grant_bot;
  logic w_fire;

  assign udp_fifo_has_data = ~udp_empty;

  assign w_decide     = (r_state == S_IDLE) && !eng_busy;
  assign w_guard_trip = (MAX_UDP_BURST != 0) && (r_burst >= BURST_LIM) && !bot_empty;
  assign w_grant_udp  = w_decide && !udp_empty && !w_guard_trip;
  // Reaching here with UDP non-empty implies the guard tripped, so bot is non-empty.
  assign w_grant_bot  = w_decide && !bot_empty && !w_grant_udp;
  assign w_fire       = ((r_state == S_LATCH) || (r_state == S_PEND)) && !eng_busy;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_grant_udp || w_grant_bot) w_next = S_READ;
      S_READ:  w_next = S_LATCH;
      S_LATCH: w_next = eng_busy ? S_PEND : S_GUARD;
      S_PEND:  if (!eng_busy) w_next = S_GUARD;
      S_GUARD: w_next = S_WAIT;
      S_WAIT:  if (!eng_busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_sel         <= 1'b0;
      r_burst       <= '0;
      udp_rd_en     <= 1'b0;
      bot_rd_en     <= 1'b0;
      eng_valid     <= 1'b0;
      eng_data      <= '0;
      eng_src       <= 1'b0;
      udp_grant_cnt <= '0;
      bot_grant_cnt <= '0;
    end else begin
      r_state   <= w_next;
      udp_rd_en <= w_grant_udp;
      bot_rd_en <= w_grant_bot;
      eng_valid <= w_fire;

      if (w_grant_udp || w_grant_bot) r_sel <= w_grant_bot;

      if (w_grant_udp) begin
        if (!bot_empty) begin
          if (r_burst != '1) r_burst <= r_burst + 1'b1;
        end else begin
          r_burst <= '0;
        end
      end else if (w_grant_bot) begin
        r_burst <= '0;
      end

      // eng_src is updated together with eng_data so the pair stays coherent
      // from one LATCH to the next.
      if (r_state == S_LATCH) begin
        eng_data <= r_sel ? bot_dout : udp_dout;
        eng_src  <= r_sel;
      end

      if (w_fire) begin
        if (r_sel) begin
          if (bot_grant_cnt != '1) bot_grant_cnt <= bot_grant_cnt + 1'b1;
        end else begin
          if (udp_grant_cnt != '1) udp_grant_cnt <= udp_grant_cnt + 1'b1;
        end
      end
    end
  end

endmodule
